oled_link_arbiter: RTL and testbench
====================================

Name: oled_link_arbiter

Overview:
- Owns the single byte-serial OLED link (8-bit byte, D/C flag) and shares it between NREQ requesters, e.g. CPU normal-mode writes, block auto-updater and a future scroll engine.
- After reset, drives the panel reset pin and plays a fixed init command sequence. Only then are requesters granted.
- Grants whole bursts round-robin and forwards bytes to the downstream SPI shifter over a valid/ready handshake.

Parameters:
- NREQ, 3, number of requesters (2..4).
- RST_CYCLES, 16, HCLK cycles oled_rst_n is held low after reset release.
- SETTLE_CYCLES, 32, HCLK cycles waited with oled_rst_n high before init.

Ports:
- HCLK  in  1  system clock; everything on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  byte for requester i at [8i+7:8i].
- req_dnc  in  NREQ  D/C flag per requester (0 = command, 1 = data).
- req_last  in  NREQ  current byte ends the burst.
- req_ack  out  NREQ  byte from requester i accepted this cycle (combinational).
- grant  out  NREQ  one-hot registered owner of the link; 0 when none.
- tx_valid  out  1  byte presented to shifter.
- tx_data  out  8  byte to shifter.
- tx_dnc  out  1  D/C for tx_data.
- tx_ready  in  1  shifter can take a byte.
- oled_rst_n  out  1  panel reset pin, active low, registered.
- init_done  out  1  init sequence complete, registered, sticky until reset.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Transfer: a byte moves on any cycle with tx_valid & tx_ready.
- tx_valid rule: once asserted, tx_valid may drop only if the source withdraws.
- Reset values: oled_rst_n=0, init_done=0, grant=0, tx_valid=0, tx_data=0, tx_dnc=0, req_ack=0, busy=1, state=RST_HOLD, counter=0, rr_ptr=NREQ-1 (so req[0] wins first).
- RST_HOLD:
  - oled_rst_n=0; counter increments.
  - When counter==RST_CYCLES-1: clear counter, go to SETTLE.
  - oled_rst_n is therefore low for exactly RST_CYCLES cycles after HRESET falls.
- SETTLE:
  - oled_rst_n=1; same count up to SETTLE_CYCLES-1, then go to INIT with idx=0.
- INIT:
  - tx_valid=1, tx_dnc=0, tx_data=ROM[idx]. ROM = AE, A0, 72, AF (4 commands, fixed).
  - On transfer: idx++.
  - Transfer at idx==3: init_done<=1, go to IDLE.
  - Requests are ignored and req_ack stays 0.
- IDLE:
  - tx_valid=0.
  - If any req: pick first set bit scanning rr_ptr+1, rr_ptr+2, ... (mod NREQ); load grant one-hot; go to BURST.
  - Arbitration costs one cycle: no byte is forwarded in IDLE.
- BURST (owner g):
  - Forwarding is combinational: tx_valid=req[g], tx_data=req_data[g], tx_dnc=req_dnc[g], req_ack[g]=req[g]&tx_ready.
  - All other req_ack bits are 0.
  - Lock is held while req[g] is low mid-burst (tx_valid=0); there is no timeout.
  - Transfer with req_last[g]=1: grant<=0, rr_ptr<=g, go to IDLE.
  - The next burst (from anyone) starts no earlier than 2 cycles after the last transfer.
- req_last is sampled only on transfer cycles. A single-byte burst is legal (req_last on first byte).
- All requests simultaneous: strict round-robin, no starvation. Each requester waits at most NREQ-1 bursts.
- Requests for NREQ bits outside the grant are ignored; a requester must hold req until acked.
- HRESET mid-operation (any state, including mid-burst or mid-init):
  - Next edge restores reset values.
  - The interrupted byte is abandoned; no ack is issued in the reset cycle.
  - Full RST_HOLD/SETTLE/INIT replays.
- Counters: counter is wide enough for max(RST_CYCLES, SETTLE_CYCLES)-1; idx is 2 bits; rr_ptr is clog2(NREQ) bits and wraps NREQ-1 -> 0.

Test Plan:
- Release HRESET, tx_ready=1:
  - oled_rst_n low 16 cycles, high 32 cycles.
  - Then AE, A0, 72, AF on consecutive cycles with tx_dnc=0.
  - init_done rises the cycle after AF; busy drops in IDLE.
- Init with tx_ready toggling 1/0 each cycle: each ROM byte held stable while stalled; exactly 4 transfers, order unchanged.
- After init, req[1] burst 3C(dnc0), 11(dnc1), 22(dnc1, last), tx_ready=1:
  - grant=010 one cycle after req.
  - 3 transfers with matching dnc, req_ack[1] on each.
  - grant=0 after 22.
- req[0], req[1], req[2] all held with 1-byte bursts: grant order 0, 1, 2, 0.
- Owner 2 drops req for 5 cycles mid-burst while req[0] high: tx_valid=0, grant stays 100, req_ack[0]=0 until owner 2's last byte.
- HRESET for 1 cycle mid-burst: next cycle grant=0, tx_valid=0, oled_rst_n=0, init_done=0; full init sequence repeats.

Source files
------------

// File: rtl/oled_link_arbiter.sv
// Owner of the byte-serial OLED link: panel reset and settle, fixed init
// command burst, then round-robin whole-burst sharing between NREQ requesters.
module oled_link_arbiter #(
  parameter int NREQ          = 3,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 32
) (
  input  logic              HCLK_i,
  input  logic              HRESET_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_dnc_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ack_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_dnc_o,
  input  logic              tx_ready_i,
  output logic              oled_rst_n_o,
  output logic              init_done_o,
  output logic              busy_o
);

  localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] PTR_INIT    = PW'(NREQ - 1);

  // RST_HOLD: pin low | SETTLE: pin high, wait | INIT: ROM bytes | IDLE: arbitrate | BURST: forward owner
  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_SETTLE,
    ST_INIT,
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      idx_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   owner_q;
  logic [NREQ-1:0] grant_q;
  logic            oled_rst_n_q;
  logic            init_done_q;

  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic            own_req;
  logic            own_xfer;

  function automatic logic [7:0] init_rom(input logic [1:0] i);
    case (i)
      2'd0:    return 8'hAE;
      2'd1:    return 8'hA0;
      2'd2:    return 8'h72;
      default: return 8'hAF;
    endcase
  endfunction

  // Scan starts one past the last owner so every requester waits at most NREQ-1 bursts.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!pick_vld && req_i[PW'((int'(rr_ptr_q) + k) % NREQ)]) begin
        pick_vld = 1'b1;
        pick_idx = PW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  assign own_req  = req_i[owner_q];
  assign own_xfer = own_req & tx_ready_i;

  always_ff @(posedge HCLK_i) begin
    if (HRESET_i) begin
      state_q      <= ST_RST_HOLD;
      cnt_q        <= '0;
      idx_q        <= '0;
      rr_ptr_q     <= PTR_INIT;
      owner_q      <= '0;
      grant_q      <= '0;
      oled_rst_n_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RST_HOLD: begin
          if (cnt_q == RST_LAST) begin
            cnt_q        <= '0;
            oled_rst_n_q <= 1'b1;
            state_q      <= ST_SETTLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_INIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_INIT: begin
          // tx_valid is constantly high here, so ready alone means a transfer.
          if (tx_ready_i) begin
            if (idx_q == 2'd3) begin
              init_done_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        ST_IDLE: begin
          if (pick_vld) begin
            grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            owner_q <= pick_idx;
            state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (own_xfer && req_last_i[owner_q]) begin
            grant_q  <= '0;
            rr_ptr_q <= owner_q;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_RST_HOLD;
      endcase
    end
  end

  // Forwarding is gated by reset so an interrupted byte is never acked.
  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    tx_dnc_o   = 1'b0;
    req_ack_o  = '0;
    if (!HRESET_i) begin
      case (state_q)
        ST_INIT: begin
          tx_valid_o = 1'b1;
          tx_data_o  = init_rom(idx_q);
        end
        ST_BURST: begin
          tx_valid_o         = own_req;
          tx_data_o          = req_data_i[8*int'(owner_q) +: 8];
          tx_dnc_o           = req_dnc_i[owner_q];
          req_ack_o[owner_q] = own_xfer;
        end
        default: ;
      endcase
    end
  end

  assign grant_o      = grant_q;
  assign oled_rst_n_o = oled_rst_n_q;
  assign init_done_o  = init_done_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_oled_link_arbiter.sv
// Directed bring-up/arbitration steps followed by randomized bursts checked
// against a burst-level round-robin reference model.
module tb_oled_link_arbiter;

  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_dnc;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   grant;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_dnc;
  logic              tx_ready;
  logic              oled_rst_n;
  logic              init_done;
  logic              busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       dnc;
    logic       last;
  } rbyte_t;

  typedef struct {
    int         who;
    logic [7:0] d;
    logic       dnc;
  } xfer_t;

  rbyte_t     rq [NREQ][$];
  xfer_t      expq[$];
  logic [7:0] rom [4];

  oled_link_arbiter #(.NREQ(NREQ), .RST_CYCLES(16), .SETTLE_CYCLES(32)) dut (
    .HCLK_i      (clk),
    .HRESET_i    (rst),
    .req_i       (req),
    .req_data_i  (req_data),
    .req_dnc_i   (req_dnc),
    .req_last_i  (req_last),
    .req_ack_o   (req_ack),
    .grant_o     (grant),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_dnc_o    (tx_dnc),
    .tx_ready_i  (tx_ready),
    .oled_rst_n_o(oled_rst_n),
    .init_done_o (init_done),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before the run completed");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One reset cycle from the current point; leaves the bench in RST_HOLD cycle 0.
  task automatic reset_cycle();
    rst = 1'b1;
    #1;
    chk("rst_cycle_ack", 32'(req_ack), 32'h0);
    chk("rst_cycle_txv", 32'(tx_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_txv", 32'(tx_valid), 32'h0);
    chk("rst_txdata", 32'(tx_data), 32'h0);
    chk("rst_txdnc", 32'(tx_dnc), 32'h0);
    chk("rst_pin", 32'(oled_rst_n), 32'h0);
    chk("rst_init_done", 32'(init_done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
  endtask

  task automatic init_seq(input bit toggle);
    int lows;
    int highs;
    int n;
    int cyc;
    lows  = 0;
    highs = 0;
    n     = 0;
    cyc   = 0;
    while (oled_rst_n === 1'b0 && lows < 200) begin
      lows++;
      step();
    end
    chk("rst_low_cycles", lows, 16);
    while (oled_rst_n === 1'b1 && tx_valid !== 1'b1 && highs < 200) begin
      highs++;
      step();
    end
    chk("settle_cycles", highs, 32);
    req      = '1;
    req_last = '1;
    while (n < 4 && cyc < 40) begin
      tx_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      chk("init_txv", 32'(tx_valid), 32'h1);
      chk("init_byte", 32'(tx_data), 32'(rom[n]));
      chk("init_dnc", 32'(tx_dnc), 32'h0);
      chk("init_ack", 32'(req_ack), 32'h0);
      if (tx_ready) n++;
      cyc++;
      step();
    end
    chk("init_xfers", n, 4);
    tx_ready = 1'b1;
    #1;
    chk("init_done_rise", 32'(init_done), 32'h1);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_txv", 32'(tx_valid), 32'h0);
    req      = '0;
    req_last = '0;
  endtask

  task automatic random_phase();
    int         nb;
    int         len;
    int         ptr;
    int         total;
    int         j;
    int         cyc;
    int         pos  [NREQ];
    int         left [NREQ];
    int         gap  [NREQ];
    rbyte_t     b;
    xfer_t      x;
    logic [NREQ-1:0] ack_s;

    total = 0;
    for (int i = 0; i < NREQ; i++) begin
      nb = $urandom_range(1, 3);
      left[i] = nb;
      pos[i]  = 0;
      gap[i]  = 0;
      total  += nb;
      for (int bb = 0; bb < nb; bb++) begin
        len = $urandom_range(1, 4);
        for (int m = 0; m < len; m++) begin
          b.d    = 8'($urandom);
          b.dnc  = 1'($urandom);
          b.last = (m == len - 1);
          rq[i].push_back(b);
        end
      end
    end

    // Reference: whole bursts served in strict rotation, first owner after the last one.
    ptr = NREQ - 1;
    while (total > 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        j = (ptr + k) % NREQ;
        if (left[j] > 0) begin
          do begin
            x.who = j;
            x.d   = rq[j][pos[j]].d;
            x.dnc = rq[j][pos[j]].dnc;
            expq.push_back(x);
            pos[j]++;
          end while (!rq[j][pos[j]-1].last);
          left[j]--;
          total--;
          ptr = j;
          break;
        end
      end
    end

    cyc = 0;
    while (expq.size() > 0 && cyc < 4000) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        req[i] = (rq[i].size() > 0) && (gap[i] == 0);
        if (rq[i].size() > 0) begin
          req_data[8*i +: 8] = rq[i][0].d;
          req_dnc[i]         = rq[i][0].dnc;
          req_last[i]        = rq[i][0].last;
        end
      end
      #1;
      ack_s = req_ack;
      if (tx_valid === 1'b1 && tx_ready) begin
        x = expq.pop_front();
        chk("rnd_grant", 32'(grant), 32'(1) << x.who);
        chk("rnd_data", 32'(tx_data), 32'(x.d));
        chk("rnd_dnc", 32'(tx_dnc), 32'(x.dnc));
        chk("rnd_ack", 32'(req_ack), 32'(1) << x.who);
      end else begin
        chk("rnd_noack", 32'(req_ack), 32'h0);
      end
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (gap[i] > 0) gap[i]--;
        if (ack_s[i] && rq[i].size() > 0) begin
          b = rq[i].pop_front();
          if (!b.last) gap[i] = $urandom_range(0, 3);
        end
      end
      cyc++;
    end
    chk("rnd_drain", expq.size(), 0);
    req = '0;
  endtask

  initial begin
    logic [7:0] bd  [3];
    logic       bdn [3];
    int         rro [4];
    int         k;
    int         cyc;

    rom[0] = 8'hAE; rom[1] = 8'hA0; rom[2] = 8'h72; rom[3] = 8'hAF;
    bd[0] = 8'h3C; bd[1] = 8'h11; bd[2] = 8'h22;
    bdn[0] = 1'b0; bdn[1] = 1'b1; bdn[2] = 1'b1;
    rro[0] = 0; rro[1] = 1; rro[2] = 2; rro[3] = 0;

    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    req_dnc  = '0;
    req_last = '0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Bring-up with the shifter always ready.
    reset_cycle();
    init_seq(1'b0);

    // Three-byte burst from requester 1.
    step();
    req            = 3'b010;
    req_data[15:8] = bd[0];
    req_dnc[1]     = bdn[0];
    req_last[1]    = 1'b0;
    #1;
    chk("b1_idle_grant", 32'(grant), 32'h0);
    chk("b1_idle_txv", 32'(tx_valid), 32'h0);
    step();
    chk("b1_grant", 32'(grant), 32'h2);
    for (int i = 0; i < 3; i++) begin
      req_data[15:8] = bd[i];
      req_dnc[1]     = bdn[i];
      req_last[1]    = (i == 2);
      #1;
      chk("b1_txv", 32'(tx_valid), 32'h1);
      chk("b1_data", 32'(tx_data), 32'(bd[i]));
      chk("b1_dnc", 32'(tx_dnc), 32'(bdn[i]));
      chk("b1_ack", 32'(req_ack), 32'h2);
      chk("b1_busy", 32'(busy), 32'h1);
      step();
    end
    req = '0;
    #1;
    chk("b1_release", 32'(grant), 32'h0);
    chk("b1_idle_busy", 32'(busy), 32'h0);

    // Bring-up again with a stalling shifter.
    reset_cycle();
    init_seq(1'b1);

    // All three hold single-byte bursts: order 0,1,2,0.
    step();
    req      = 3'b111;
    req_last = 3'b111;
    req_dnc  = 3'b000;
    req_data = {8'hA2, 8'hA1, 8'hA0};
    k   = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      #1;
      if (tx_valid === 1'b1 && tx_ready) begin
        chk("rr_grant", 32'(grant), 32'(1) << rro[k]);
        chk("rr_data", 32'(tx_data), 32'h0A0 + 32'(rro[k]));
        k++;
      end
      cyc++;
      step();
    end
    chk("rr_count", k, 4);
    req      = '0;
    req_last = '0;

    // Owner 2 pauses mid-burst while requester 0 waits.
    req             = 3'b100;
    req_data[23:16] = 8'h55;
    req_dnc[2]      = 1'b1;
    req_last[2]     = 1'b0;
    #1;
    step();
    chk("gap_grant", 32'(grant), 32'h4);
    req[0]        = 1'b1;
    req_data[7:0] = 8'h66;
    req_dnc[0]    = 1'b0;
    req_last[0]   = 1'b1;
    #1;
    chk("gap_first_data", 32'(tx_data), 32'h55);
    chk("gap_first_ack", 32'(req_ack), 32'h4);
    step();
    req[2] = 1'b0;
    repeat (5) begin
      #1;
      chk("gap_txv", 32'(tx_valid), 32'h0);
      chk("gap_grant_hold", 32'(grant), 32'h4);
      chk("gap_ack", 32'(req_ack), 32'h0);
      step();
    end
    req[2]          = 1'b1;
    req_data[23:16] = 8'h77;
    req_last[2]     = 1'b1;
    #1;
    chk("gap_last_data", 32'(tx_data), 32'h77);
    chk("gap_last_ack", 32'(req_ack), 32'h4);
    step();
    req[2] = 1'b0;
    #1;
    chk("gap_release", 32'(grant), 32'h0);
    chk("gap_req0_wait", 32'(req_ack), 32'h0);
    step();
    chk("gap_next_grant", 32'(grant), 32'h1);
    #1;
    chk("gap_req0_data", 32'(tx_data), 32'h66);
    chk("gap_req0_ack", 32'(req_ack), 32'h1);
    step();
    req      = '0;
    req_last = '0;

    // Reset lands in the middle of a burst.
    req            = 3'b010;
    req_data[15:8] = 8'h99;
    req_dnc[1]     = 1'b1;
    req_last[1]    = 1'b0;
    #1;
    step();
    chk("mr_grant", 32'(grant), 32'h2);
    #1;
    chk("mr_txv_before", 32'(tx_valid), 32'h1);
    reset_cycle();
    req = '0;
    init_seq(1'b0);

    // Randomized bursts against the rotation model.
    step();
    random_phase();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
